// File: rtl/video_source.sv
// Raster-order frame reader: walks a W x H image out of a 1-cycle-latency
// frame memory and emits the Pixel/Frame/Line stream for the Hough pipeline.
module video_source #(
  parameter int H_BLANK = 4,
  parameter int V_BLANK = 16,
  parameter int ADDR_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Continuous,
  input  logic [7:0]        Width,
  input  logic [7:0]        Height,
  output logic              MemRd,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MemData,
  output logic [7:0]        PixelOut,
  output logic              FrameOut,
  output logic              LineOut,
  output logic              Busy,
  output logic              FrameDone
);

  localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int CNT_W     = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;
  localparam int STAGES    = 1;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_BLANK - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  typedef struct packed {
    logic lineFirst;
    logic frameFirst;
    logic frameLast;
  } tag_t;

  state_t            state, nextState;
  logic [7:0]        w, h, col, row;
  logic [7:0]        nextW, nextH, nextCol, nextRow;
  logic [CNT_W-1:0]  blankCnt, nextBlank;
  logic [ADDR_W-1:0] addr, nextAddr;
  logic [STAGES-1:0] vldQ;
  logic [STAGES:0]   vldPipe;
  tag_t              rdTag, outTag;
  logic              lastCol, lastRow, dimsOk, launch;

  assign lastCol = (col == w - 8'd1);
  assign lastRow = (row == h - 8'd1);
  assign dimsOk  = (Width != 8'd0) && (Height != 8'd0);

  // A frame begins either from an explicit Start in IDLE or by chaining at
  // the end of vertical blanking; both paths latch the live Width/Height.
  assign launch = dimsOk &&
                  (((state == IDLE) && Start) ||
                   ((state == VBLANK) && (blankCnt == V_LAST) && Continuous));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      w        <= '0;
      h        <= '0;
      col      <= '0;
      row      <= '0;
      blankCnt <= '0;
      addr     <= '0;
    end else begin
      state    <= nextState;
      w        <= nextW;
      h        <= nextH;
      col      <= nextCol;
      row      <= nextRow;
      blankCnt <= nextBlank;
      addr     <= nextAddr;
    end
  end

  always_comb begin
    nextState = state;
    nextW     = w;
    nextH     = h;
    nextCol   = col;
    nextRow   = row;
    nextBlank = blankCnt;
    nextAddr  = addr;
    unique case (state)
      IDLE: ;
      ACTIVE: begin
        nextAddr = addr + 1'b1;
        nextCol  = col + 8'd1;
        if (lastCol) begin
          nextCol   = '0;
          nextBlank = '0;
          if (lastRow) begin
            nextState = VBLANK;
          end else begin
            nextRow = row + 8'd1;
            if (H_BLANK != 0) nextState = HBLANK;
          end
        end
      end
      HBLANK: begin
        nextBlank = blankCnt + 1'b1;
        if (blankCnt == H_LAST) nextState = ACTIVE;
      end
      VBLANK: begin
        nextBlank = blankCnt + 1'b1;
        if (blankCnt == V_LAST) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (launch) begin
      nextState = ACTIVE;
      nextW     = Width;
      nextH     = Height;
      nextCol   = '0;
      nextRow   = '0;
      nextBlank = '0;
      nextAddr  = '0;
    end
  end

  assign MemRd   = (state == ACTIVE);
  assign MemAddr = addr;
  assign Busy    = (state != IDLE);

  // Strobes ride one stage behind the read so they line up with MemData.
  assign rdTag.lineFirst  = (col == 8'd0);
  assign rdTag.frameFirst = (col == 8'd0) && (row == 8'd0);
  assign rdTag.frameLast  = lastCol && lastRow;
  assign vldPipe          = {vldQ, MemRd};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vldQ   <= '0;
      outTag <= '0;
    end else begin
      vldQ   <= vldPipe[STAGES-1:0];
      outTag <= MemRd ? rdTag : '0;
    end
  end

  assign PixelOut  = vldPipe[STAGES] ? MemData : 8'h00;
  assign LineOut   = outTag.lineFirst;
  assign FrameOut  = outTag.frameFirst;
  assign FrameDone = outTag.frameLast;

endmodule

// File: tb/tb_video_source.sv
// Bench for video_source: table of frame shapes, randomized frames against a
// raster-schedule model, plus hand-written chaining, zero-blank and abort cases.
module tb_video_source;
  localparam int AW = 16;
  localparam int HB = 4;
  localparam int VB = 16;

  logic          Clk = 1'b0, Reset = 1'b0;
  logic          Start = 1'b0, Continuous = 1'b0;
  logic [7:0]    Width = '0, Height = '0;
  logic          MemRd, FrameOut, LineOut, Busy, FrameDone;
  logic [AW-1:0] MemAddr;
  logic [7:0]    MemData = '0, PixelOut;

  logic          Start1 = 1'b0;
  logic [7:0]    Width1 = '0, Height1 = '0;
  logic          MemRd1, FrameOut1, LineOut1, Busy1, FrameDone1;
  logic [AW-1:0] MemAddr1;
  logic [7:0]    MemData1 = '0, PixelOut1;

  logic [7:0] mem [0:65535];
  int nChk = 0, nFail = 0;

  video_source #(.H_BLANK(HB), .V_BLANK(VB), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Continuous(Continuous),
    .Width(Width), .Height(Height), .MemRd(MemRd), .MemAddr(MemAddr),
    .MemData(MemData), .PixelOut(PixelOut), .FrameOut(FrameOut),
    .LineOut(LineOut), .Busy(Busy), .FrameDone(FrameDone));

  video_source #(.H_BLANK(0), .V_BLANK(1), .ADDR_W(AW)) dutNoBlank (
    .Clk(Clk), .Reset(Reset), .Start(Start1), .Continuous(1'b0),
    .Width(Width1), .Height(Height1), .MemRd(MemRd1), .MemAddr(MemAddr1),
    .MemData(MemData1), .PixelOut(PixelOut1), .FrameOut(FrameOut1),
    .LineOut(LineOut1), .Busy(Busy1), .FrameDone(FrameDone1));

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (MemRd)  MemData  <= mem[MemAddr];
    if (MemRd1) MemData1 <= mem[MemAddr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference schedule: one slot per cycle after the Start edge.
  typedef struct {bit rd; int addr; bit lf; bit ff; bit fl;} slot_t;
  slot_t slots[$];

  function automatic void buildModel(input int w, input int h, input int hb, input int vb);
    slot_t s;
    slot_t idle = '{default: 0};
    slots.delete();
    if (w == 0 || h == 0) return;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        s.rd = 1'b1; s.addr = r * w + c;
        s.lf = (c == 0); s.ff = (c == 0 && r == 0); s.fl = (r == h - 1 && c == w - 1);
        slots.push_back(s);
      end
      if (r < h - 1) for (int i = 0; i < hb; i++) slots.push_back(idle);
    end
    for (int i = 0; i < vb; i++) slots.push_back(idle);
  endfunction

  task automatic runFrame(input int w, input int h, input bit poke,
                          output int nRd, output int nLine, output int nBusy, output int lineAtDone);
    int L, nCyc;
    slot_t cur, prv;
    slot_t idle = '{default: 0};
    logic [12:0] expV, actV;
    buildModel(w, h, HB, VB);
    L = slots.size();
    nCyc = (L < 20) ? 20 : L + 1;
    nRd = 0; nLine = 0; nBusy = 0; lineAtDone = -1;
    @(negedge Clk); Width = w[7:0]; Height = h[7:0]; Start = 1'b1;
    @(negedge Clk); Start = 1'b0; Width = 8'($urandom); Height = 8'($urandom);
    for (int t = 0; t < nCyc; t++) begin
      cur  = (t < L) ? slots[t] : idle;
      prv  = (t >= 1 && t - 1 < L) ? slots[t-1] : idle;
      expV = {cur.rd, (prv.rd ? mem[prv.addr] : 8'h00), prv.lf, prv.ff, prv.fl, (t < L)};
      actV = {MemRd, PixelOut, LineOut, FrameOut, FrameDone, Busy};
      check($sformatf("frame %0dx%0d t=%0d {rd,pix,line,frame,done,busy}", w, h, t), actV, expV);
      if (cur.rd) check($sformatf("frame %0dx%0d t=%0d addr", w, h, t), MemAddr, cur.addr);
      nRd += MemRd; nLine += LineOut; nBusy += Busy;
      if (FrameDone) lineAtDone = nLine;
      Start = poke && (L >= 2) && (t == L - 2);
      @(negedge Clk);
    end
    Start = 1'b0;
  endtask

  typedef struct {int w; int h; int expPix; int expLines; int expBusy; bit fill;} vec_t;
  vec_t tbl[6];

  initial begin
    int nRd, nLine, nBusy, lad, w, h;
    int f0, f1, nF, prevAddr, addrAtStart, cyc;
    logic prevRd, rdAtStart;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    tbl[0] = '{4, 3, 12, 3, 36, 1'b0};
    tbl[1] = '{0, 5, 0, 0, 0, 1'b0};
    tbl[2] = '{5, 0, 0, 0, 0, 1'b0};
    tbl[3] = '{1, 1, 1, 1, 17, 1'b0};
    tbl[4] = '{3, 2, 6, 2, 26, 1'b0};
    tbl[5] = '{1, 255, 255, 255, 1287, 1'b1};

    #1 Reset = 1'b1;
    #11;
    check("reset dut outputs", {MemRd, MemAddr, PixelOut, LineOut, FrameOut, FrameDone, Busy}, 0);
    check("reset dutNoBlank outputs", {MemRd1, MemAddr1, PixelOut1, LineOut1, FrameOut1, FrameDone1, Busy1}, 0);
    @(negedge Clk); Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < 1024; a++) mem[a] = tbl[i].fill ? 8'hAA : 8'(a);
      runFrame(tbl[i].w, tbl[i].h, 1'b0, nRd, nLine, nBusy, lad);
      check($sformatf("vec%0d pixel count", i), nRd, tbl[i].expPix);
      check($sformatf("vec%0d line count", i), nLine, tbl[i].expLines);
      check($sformatf("vec%0d busy cycles", i), nBusy, tbl[i].expBusy);
      if (tbl[i].expPix > 0) check($sformatf("vec%0d FrameDone on last line", i), lad, tbl[i].expLines);
    end

    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(1, 9); h = $urandom_range(1, 6);
      for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
      runFrame(w, h, k[0], nRd, nLine, nBusy, lad);
      check("rand pixel count", nRd, w * h);
      check("rand line count", nLine, h);
      check("rand busy cycles", nBusy, w * h + (h - 1) * HB + VB);
    end

    // Continuous chaining
    for (int a = 0; a < 64; a++) mem[a] = 8'(a + 100);
    Continuous = 1'b1;
    @(negedge Clk); Width = 2; Height = 2; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    f0 = -1; f1 = -1; nF = 0; prevAddr = -1; prevRd = 1'b0; addrAtStart = -1; rdAtStart = 1'b0;
    for (cyc = 0; cyc < 80; cyc++) begin
      if (FrameOut) begin
        if (nF == 0) f0 = cyc;
        else if (nF == 1) begin f1 = cyc; addrAtStart = prevAddr; rdAtStart = prevRd; end
        nF++;
        if (nF == 2) Continuous = 1'b0;
      end
      prevAddr = MemAddr; prevRd = MemRd;
      @(negedge Clk);
    end
    Continuous = 1'b0;
    check("chain FrameOut spacing", f1 - f0, 2 + HB + 2 + VB);
    check("chain restart addr", addrAtStart, 0);
    check("chain restart read", rdAtStart, 1'b1);
    check("chain frame count", nF, 2);
    check("chain ends idle", Busy, 1'b0);

    // Zero horizontal blanking
    for (int a = 0; a < 64; a++) mem[a] = 8'(a * 3 + 1);
    @(negedge Clk); Width1 = 3; Height1 = 2; Start1 = 1'b1;
    @(negedge Clk); Start1 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      check($sformatf("noblank t=%0d rd", t), MemRd1, t < 6);
      if (t < 6) check($sformatf("noblank t=%0d addr", t), MemAddr1, t);
      check($sformatf("noblank t=%0d pix", t), PixelOut1, (t >= 1 && t <= 6) ? mem[t-1] : 8'h00);
      check($sformatf("noblank t=%0d line", t), LineOut1, t == 1 || t == 4);
      check($sformatf("noblank t=%0d frame", t), FrameOut1, t == 1);
      check($sformatf("noblank t=%0d done", t), FrameDone1, t == 6);
      check($sformatf("noblank t=%0d busy", t), Busy1, t < 7);
      @(negedge Clk);
    end

    // Reset during the second line
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    @(negedge Clk); Width = 4; Height = 3; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("abort pre {rd,line,busy}", {MemRd, LineOut, Busy}, 3'b111);
    #2 Reset = 1'b1;
    #1 check("abort outputs", {MemRd, MemAddr, PixelOut, LineOut, FrameOut, FrameDone, Busy}, 0);
    @(negedge Clk); Reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge Clk);
      check($sformatf("post-abort quiet t=%0d", t), {MemRd, PixelOut, LineOut, FrameOut, FrameDone, Busy}, 0);
    end
    runFrame(4, 3, 1'b0, nRd, nLine, nBusy, lad);
    check("post-abort pixel count", nRd, 12);
    check("post-abort busy cycles", nBusy, 36);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
